// File: rtl/hls_seq_pkg.sv
// Shared types and default sizing for the hlsyn job sequencer.
// The HLS_SEQ_TIMEOUT_EN build adds a WAIT watchdog; these defaults apply to both builds.
package hls_seq_pkg;

  localparam int DEF_DW             = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic signed [DEF_DW-1:0]   z;
    logic signed [2*DEF_DW-1:0] x;
    logic                       err;
  } result_t;

endpackage

// File: rtl/hls_job_sequencer_if.sv
// Job-in, kernel Start/Done and result-out handshakes of the sequencer, bundled as one interface.
// master = sequencer side; slave = host stream plus kernel side.
interface hls_job_sequencer_if #(
  parameter int DW = hls_seq_pkg::DEF_DW
);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_a;
  logic signed [DW-1:0] in_b;
  logic signed [DW-1:0] in_c;

  logic                 k_start;
  logic signed [DW-1:0] k_a;
  logic signed [DW-1:0] k_b;
  logic signed [DW-1:0] k_c;
  logic                 k_done;
  logic signed [DW-1:0] k_z;
  logic signed [2*DW-1:0] k_x;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_z;
  logic signed [2*DW-1:0] out_x;
  logic                 out_err;

  modport master (
    input  in_valid, in_a, in_b, in_c,
    output in_ready,
    output k_start, k_a, k_b, k_c,
    input  k_done, k_z, k_x,
    output out_valid, out_z, out_x, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_a, in_b, in_c,
    input  in_ready,
    input  k_start, k_a, k_b, k_c,
    output k_done, k_z, k_x,
    input  out_valid, out_z, out_x, out_err,
    output out_ready
  );

endinterface

// File: rtl/hls_seq_watchdog.sv
// Down-counting WAIT watchdog; only compiled when HLS_SEQ_TIMEOUT_EN is defined.
// clear reloads the limit, enable counts, expire flags the last allowed enabled cycle.
`ifdef HLS_SEQ_TIMEOUT_EN
module hls_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = hls_seq_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // terminal count reached on an enabled cycle: TIMEOUT_CYCLES enabled cycles have elapsed
  assign expire_o = enable_i && (cnt_q == '0);

endmodule
`endif

// File: rtl/hls_job_sequencer.sv
// Initiator for the hlsyn Start/Done kernel handshake: one job in flight, results returned on valid/ready.
// HLS_SEQ_TIMEOUT_EN adds a WAIT watchdog that aborts the job with out_err=1.
//
//  state | meaning
//  IDLE  | in_ready high, waiting for an operand job
//  START | k_start pulse, operands on k_a/b/c
//  WAIT  | waiting for k_done (or watchdog expiry)
//  RESP  | out_valid high, result held until out_ready
module hls_job_sequencer
  import hls_seq_pkg::*;
#(
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  hls_job_sequencer_if.master  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     jobs_done
);

  seq_state_e             state_q, state_d;
  logic signed [DW-1:0]   ka_q, ka_d;
  logic signed [DW-1:0]   kb_q, kb_d;
  logic signed [DW-1:0]   kc_q, kc_d;
  logic signed [DW-1:0]   z_q, z_d;
  logic signed [2*DW-1:0] x_q, x_d;
  logic [CNT_W-1:0]       jobs_q, jobs_d;
  logic                   accept;

`ifdef HLS_SEQ_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_clear, wd_enable, wd_expire;

  assign wd_clear  = (state_q == START);
  assign wd_enable = (state_q == WAIT);

  hls_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expire_o (wd_expire)
  );
`endif

  // in_ready is also masked during the reset cycle itself
  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    kc_d    = kc_q;
    z_d     = z_q;
    x_d     = x_q;
    jobs_d  = jobs_q;
`ifdef HLS_SEQ_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          ka_d    = bus.in_a;
          kb_d    = bus.in_b;
          kc_d    = bus.in_c;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.k_done) begin
          z_d     = bus.k_z;
          x_d     = bus.k_x;
`ifdef HLS_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef HLS_SEQ_TIMEOUT_EN
        else if (wd_expire) begin
          z_d     = '0;
          x_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        if (bus.out_ready) begin
          jobs_d  = jobs_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ka_q    <= '0;
      kb_q    <= '0;
      kc_q    <= '0;
      z_q     <= '0;
      x_q     <= '0;
      jobs_q  <= '0;
`ifdef HLS_SEQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      kc_q    <= kc_d;
      z_q     <= z_d;
      x_q     <= x_d;
      jobs_q  <= jobs_d;
`ifdef HLS_SEQ_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.k_start   = (state_q == START);
  assign bus.k_a       = ka_q;
  assign bus.k_b       = kb_q;
  assign bus.k_c       = kc_q;
  assign bus.out_valid = (state_q == RESP);
  assign bus.out_z     = z_q;
  assign bus.out_x     = x_q;
`ifdef HLS_SEQ_TIMEOUT_EN
  assign bus.out_err   = err_q;
`else
  assign bus.out_err   = 1'b0;
`endif
  assign busy          = (state_q != IDLE);
  assign jobs_done     = jobs_q;

endmodule

// File: tb/tb_hls_job_sequencer.sv
// Self-checking bench for hls_job_sequencer: stub kernel (z=a+b, x=a*c, Done after lat cycles),
// directed vector table, corner sequences, and a randomized run against a timing/result model.
module tb_hls_job_sequencer;
  import hls_seq_pkg::*;

  localparam int DW    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] jobs_done;

  hls_job_sequencer_if #(.DW(DW)) bus();

  hls_job_sequencer #(
    .DW             (DW),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int exp_jobs = 0;

  // stub kernel controls, written by the main thread only
  int lat  = 1;
  bit hang = 1'b0;
  bit spur = 1'b0;
  int cd   = -1;

  // stub kernel: Done exactly lat cycles after the Start cycle; result buses carry junk otherwise
  always @(negedge clk) begin
    if (bus.k_start && !hang) cd = lat;
    else if (cd >= 0) cd = cd - 1;
    bus.k_done = (cd == 0) || spur;
    if (bus.k_done) begin
      bus.k_z = 8'(int'(bus.k_a) + int'(bus.k_b));
      bus.k_x = 16'(int'(bus.k_a) * int'(bus.k_c));
    end else begin
      bus.k_z = 8'($urandom);
      bus.k_x = 16'($urandom);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // entered at a negedge; returns at the negedge where out_valid rises (or bound hit)
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      step();
      sample();
      n++;
    end
    check("out_valid_wait", bus.out_valid, 1);
  endtask

  task automatic run_job(input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic signed [7:0] c, input int l,
                         input logic signed [7:0] ez, input logic signed [15:0] ex);
    int n;
    bus.in_a = a; bus.in_b = b; bus.in_c = c;
    lat = l;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    sample();
    check("in_ready_idle", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    sample();
    check("k_start_pulse", bus.k_start, 1);
    check("k_a", 32'(bus.k_a), 32'(a));
    check("k_b", 32'(bus.k_b), 32'(b));
    check("k_c", 32'(bus.k_c), 32'(c));
    step();
    sample();
    check("k_start_one_cycle", bus.k_start, 0);
    wait_valid(n);
    check("latency_from_start", n + 1, l + 1);
    check("out_z", 32'(bus.out_z), 32'(ez));
    check("out_x", 32'(bus.out_x), 32'(ex));
    check("out_err", bus.out_err, 0);
    check("in_ready_resp", bus.in_ready, 0);
    exp_jobs++;
    step();
    sample();
    check("out_valid_drop", bus.out_valid, 0);
    check("jobs_done", jobs_done, exp_jobs);
    check("in_ready_back", bus.in_ready, 1);
    step();
  endtask

  typedef struct {
    logic signed [7:0]  a, b, c;
    int                 lat;
    logic signed [7:0]  z;
    logic signed [15:0] x;
  } vec_t;

  vec_t    tbl [6];
  vec_t    bb [3];
  result_t bb_exp [3];

  // randomized-run model: one job in flight, result due at accept + 2 + lat
  bit                 m_inflight;
  int                 m_tv;
  logic signed [7:0]  m_z;
  logic signed [15:0] m_x;
  int                 m_jobs;

  initial begin
    #400000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int j, k;
    int acc [3];

    tbl[0] = '{a: 8'sd3,    b: -8'sd2,  c: 8'sd5,    lat: 4, z: 8'sd1,   x: 16'sd15};
    tbl[1] = '{a: 8'sh80,   b: -8'sd1,  c: 8'sh80,   lat: 1, z: 8'sd127, x: 16'sd16384};
    tbl[2] = '{a: 8'sd127,  b: 8'sd127, c: 8'sd127,  lat: 2, z: -8'sd2,  x: 16'sd16129};
    tbl[3] = '{a: -8'sd1,   b: 8'sd0,   c: -8'sd1,   lat: 3, z: -8'sd1,  x: 16'sd1};
    tbl[4] = '{a: 8'sd100,  b: 8'sd27,  c: -8'sd3,   lat: 1, z: 8'sd127, x: -16'sd300};
    tbl[5] = '{a: 8'sh80,   b: 8'sh80,  c: 8'sd127,  lat: 5, z: 8'sd0,   x: -16'sd16256};

    bb[0] = '{a: 8'sh80, b: -8'sd1, c: 8'sh80, lat: 1, z: 8'sd0, x: 16'sd0};
    bb[1] = '{a: 8'sd5,  b: 8'sd6,  c: 8'sd7,  lat: 1, z: 8'sd0, x: 16'sd0};
    bb[2] = '{a: -8'sd7, b: 8'sd2,  c: 8'sd9,  lat: 1, z: 8'sd0, x: 16'sd0};
    bb_exp[0] = '{z: 8'sd127, x: 16'sd16384, err: 1'b0};
    bb_exp[1] = '{z: 8'sd11,  x: 16'sd35,    err: 1'b0};
    bb_exp[2] = '{z: -8'sd5,  x: -16'sd63,   err: 1'b0};

    // reset state
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
    repeat (3) step();
    sample();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_k_start", bus.k_start, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_out_z", 32'(bus.out_z), 0);
    check("rst_out_x", 32'(bus.out_x), 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_k_a", 32'(bus.k_a), 0);
    step();
    rst = 1'b0;
    sample();
    check("post_rst_in_ready", bus.in_ready, 1);
    step();

    // directed job table
    for (int i = 0; i < 6; i++)
      run_job(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].lat, tbl[i].z, tbl[i].x);

    // backpressure: result held 10 cycles, new job offered but not taken
    bus.in_a = 8'sd10; bus.in_b = 8'sd20; bus.in_c = -8'sd3;
    lat = 2; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_a = 8'sd99; bus.in_b = 8'sd1; bus.in_c = 8'sd1;
    sample();
    wait_valid(n);
    check("bp_latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_z", 32'(bus.out_z), 32'(30));
      check("bp_out_x", 32'(bus.out_x), 32'(-30));
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_k_a", 32'(bus.k_a), 32'(10));
      check("bp_jobs_done", jobs_done, exp_jobs);
      step();
      sample();
    end
    step();
    bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    sample();
    check("bp_handoff_valid", bus.out_valid, 1);
    step();
    sample();
    exp_jobs++;
    check("bp_valid_drop", bus.out_valid, 0);
    check("bp_jobs_done_inc", jobs_done, exp_jobs);
    step();

    // back-to-back, in_valid held high, L=1
    lat = 1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.in_a = bb[0].a; bus.in_b = bb[0].b; bus.in_c = bb[0].c;
    j = 0; k = 0;
    for (int t = 0; t < 40 && k < 3; t++) begin
      sample();
      if (bus.in_valid && bus.in_ready && j < 3) begin
        acc[j] = cyc;
        j++;
      end
      if (bus.out_valid && bus.out_ready && k < 3) begin
        check("b2b_out_z", 32'(bus.out_z), 32'(bb_exp[k].z));
        check("b2b_out_x", 32'(bus.out_x), 32'(bb_exp[k].x));
        k++;
      end
      step();
      if (j < 3) begin
        bus.in_a = bb[j].a; bus.in_b = bb[j].b; bus.in_c = bb[j].c;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    check("b2b_results", k, 3);
    check("b2b_gap1", acc[1] - acc[0], 4);
    check("b2b_gap2", acc[2] - acc[1], 4);
    exp_jobs += 3;
    sample();
    check("b2b_jobs_done", jobs_done, exp_jobs);
    step();

    // spurious Done in IDLE, then in START
    spur = 1'b1;
    sample();
    step();
    spur = 1'b0;
    sample();
    check("spur_idle_busy", busy, 0);
    check("spur_idle_valid", bus.out_valid, 0);
    check("spur_idle_start", bus.k_start, 0);
    check("spur_idle_ready", bus.in_ready, 1);
    hang = 1'b1;
    bus.in_a = 8'sd4; bus.in_b = 8'sd5; bus.in_c = 8'sd6; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0; spur = 1'b1;
    sample();
    check("spur_start_kstart", bus.k_start, 1);
    step();
    spur = 1'b0;
    sample();
    check("spur_start_kstart_low", bus.k_start, 0);
    check("spur_start_valid", bus.out_valid, 0);
    check("spur_start_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      check("wait_hold_valid", bus.out_valid, 0);
      check("wait_hold_busy", busy, 1);
    end
    step();
    spur = 1'b1;
    sample();
    step();
    spur = 1'b0;
    sample();
    check("wait_done_valid", bus.out_valid, 1);
    check("wait_done_z", 32'(bus.out_z), 32'(9));
    check("wait_done_x", 32'(bus.out_x), 32'(24));
    step();
    sample();
    exp_jobs++;
    check("spur_jobs_done", jobs_done, exp_jobs);
    check("spur_valid_drop", bus.out_valid, 0);
    step();
    hang = 1'b0;

    // reset in the middle of WAIT; stub Done arrives later in IDLE
    bus.in_a = 8'sd7; bus.in_b = 8'sd8; bus.in_c = 8'sd2;
    lat = 6; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    sample();
    step(); sample();
    step(); sample();
    check("mid_wait_busy", busy, 1);
    step();
    rst = 1'b1;
    sample();
    check("mid_rst_in_ready", bus.in_ready, 0);
    step();
    rst = 1'b0;
    exp_jobs = 0;
    sample();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_kstart", bus.k_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_jobs", jobs_done, 0);
    check("mid_rst_k_a", 32'(bus.k_a), 0);
    check("mid_rst_in_ready_back", bus.in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      sample();
      check("late_done_valid", bus.out_valid, 0);
      check("late_done_busy", busy, 0);
    end
    step();

`ifdef HLS_SEQ_TIMEOUT_EN
    // kernel never answers: watchdog abort after 8 WAIT cycles
    hang = 1'b1;
    bus.in_a = 8'sd5; bus.in_b = 8'sd6; bus.in_c = 8'sd7;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    sample();
    check("to_kstart", bus.k_start, 1);
    wait_valid(n);
    check("to_latency", n, 9);
    check("to_err", bus.out_err, 1);
    check("to_z", 32'(bus.out_z), 0);
    check("to_x", 32'(bus.out_x), 0);
    step();
    spur = 1'b1;
    sample();
    step();
    spur = 1'b0;
    sample();
    check("to_stray_valid", bus.out_valid, 1);
    check("to_stray_err", bus.out_err, 1);
    check("to_stray_z", 32'(bus.out_z), 0);
    step();
    bus.out_ready = 1'b1;
    sample();
    step();
    sample();
    exp_jobs++;
    check("to_jobs_done", jobs_done, exp_jobs);
    check("to_valid_drop", bus.out_valid, 0);
    step();
    hang = 1'b0;
`endif

    // randomized traffic against the timing/result model
    m_inflight = 1'b0;
    m_tv = 0;
    m_jobs = exp_jobs;
    m_z = '0;
    m_x = '0;
    for (int t = 0; t < 400; t++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a = 8'($urandom);
      bus.in_b = 8'($urandom);
      bus.in_c = 8'($urandom);
      if (!m_inflight) lat = $urandom_range(1, 6);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      sample();
      check("rnd_in_ready", bus.in_ready, !m_inflight);
      check("rnd_out_valid", bus.out_valid, m_inflight && (cyc >= m_tv));
      if (m_inflight && (cyc >= m_tv)) begin
        check("rnd_out_z", 32'(bus.out_z), 32'(m_z));
        check("rnd_out_x", 32'(bus.out_x), 32'(m_x));
        check("rnd_out_err", bus.out_err, 0);
      end
      check("rnd_jobs_done", jobs_done, m_jobs[CNT_W-1:0]);
      if (!m_inflight && bus.in_valid) begin
        m_inflight = 1'b1;
        m_tv = cyc + 2 + lat;
        m_z = 8'(int'(bus.in_a) + int'(bus.in_b));
        m_x = 16'(int'(bus.in_a) * int'(bus.in_c));
      end else if (m_inflight && (cyc >= m_tv) && bus.out_ready) begin
        m_inflight = 1'b0;
        m_jobs++;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
